// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; stalls the pipeline while a division is in flight.
// Optional build macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// bypass the iterative loop and complete one cycle after acceptance.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_req_i,
  input  logic [1:0]      div_ops_i,
  input  logic [XLEN-1:0] operand_1_i,
  input  logic [XLEN-1:0] operand_2_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN:0]   ONE_EXT = {{XLEN{1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  is_rem;
  logic                  q_neg, r_neg, dz, ovf;
  logic [XLEN-1:0]       quo, rem, dvsr, dvnd;

  logic                  accept;
  logic                  signed_op;
  logic                  dz_in, ovf_in;
  logic [XLEN:0]         rem_sh, diff;
  logic                  ge;
  logic [XLEN-1:0]       rem_nx, quo_nx, final_res;

  // Magnitude computed in XLEN+1 bits so the most negative value stays exact.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN:0] e;
    e = {sgn & v[XLEN-1], v};
    if (e[XLEN]) e = ~e + ONE_EXT;
    return e[XLEN-1:0];
  endfunction

  // Conditional two's-complement negation, again widened by one bit.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    logic [XLEN:0] e;
    e = {1'b0, v};
    if (neg) e = ~e + ONE_EXT;
    return e[XLEN-1:0];
  endfunction

  // Architectural results for the corner cases take precedence over the loop output.
  function automatic logic [XLEN-1:0] fix_result(input logic rem_op, input logic zero_div,
                                                 input logic overflow, input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] dividend);
    logic [XLEN-1:0] res;
    if (zero_div)      res = rem_op ? dividend : {XLEN{1'b1}};
    else if (overflow) res = rem_op ? {XLEN{1'b0}} : INT_MIN;
    else               res = rem_op ? r : q;
    return res;
  endfunction

  assign accept    = (state == IDLE) & div_req_i & ~kill_i;
  assign stall_o   = accept | (state == CALC);
  assign signed_op = ~div_ops_i[0];
  assign dz_in     = (operand_2_i == {XLEN{1'b0}});
  assign ovf_in    = signed_op & (operand_1_i == INT_MIN) & (operand_2_i == {XLEN{1'b1}});

  // One restoring shift-subtract step plus the sign-fixed result of the final step.
  always_comb begin
    rem_sh    = {rem, quo[XLEN-1]};
    diff      = rem_sh - {1'b0, dvsr};
    ge        = ~diff[XLEN];
    rem_nx    = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx    = {quo[XLEN-2:0], ge};
    final_res = fix_result(is_rem, dz, ovf, cond_neg(quo_nx, q_neg), cond_neg(rem_nx, r_neg), dvnd);
  end

  // Datapath registers: loaded at acceptance, shifted every CALC cycle; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_rem <= div_ops_i[1];
      q_neg  <= signed_op & ~div_ops_i[1] & (operand_1_i[XLEN-1] ^ operand_2_i[XLEN-1]);
      r_neg  <= signed_op & div_ops_i[1] & operand_1_i[XLEN-1];
      dz     <= dz_in;
      ovf    <= ovf_in;
      dvnd   <= operand_1_i;
      quo    <= abs_val(operand_1_i, signed_op);
      dvsr   <= abs_val(operand_2_i, signed_op);
      rem    <= {XLEN{1'b0}};
    end else if (state == CALC) begin
      quo    <= quo_nx;
      rem    <= rem_nx;
    end
  end

  // Sequencing FSM with registered done pulse and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (kill_i) begin
      state    <= IDLE;
      done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (div_req_i) begin
            cnt   <= CNT_W'(XLEN - 1);
`ifdef DIV_FAST_PATH_EN
            if (dz_in | ovf_in) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= fix_result(div_ops_i[1], dz_in, ovf_in, '0, '0, operand_1_i);
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= final_res;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer (XLEN=32).
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int LAT = 33;
`ifdef DIV_FAST_PATH_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_req = 1'b0;
  logic [1:0]  ops = 2'b00;
  logic [31:0] op1 = '0, op2 = '0;
  logic        kill = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_fail = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .div_req_i(div_req), .div_ops_i(ops),
    .operand_1_i(op1), .operand_2_i(op2), .kill_i(kill),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op and follow it cycle by cycle until done_o or the budget runs out.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int done_cyc;
    int stall_errs;
    logic [31:0] got;
    done_cyc = -1;
    got = 'x;
    @(negedge clk);
    div_req = 1'b1; ops = op; op1 = a; op2 = b;
    #1;
    stall_errs = (stall_o !== 1'b1) ? 1 : 0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (done_o === 1'b1) begin
        done_cyc = c;
        got = result_o;
        if (stall_o !== 1'b0) stall_errs++;
        div_req = 1'b0;
      end else if (stall_o !== 1'b1) begin
        stall_errs++;
      end
    end
    div_req = 1'b0;
    n_cmp++;
    if (done_cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, lat);
    end
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, got, exp);
    end
    n_cmp++;
    if (stall_errs != 0) begin
      n_fail++;
      $display("FAIL %s stall pattern: got %0d bad cycles expected 0", name, stall_errs);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || result_o !== exp) begin
      n_fail++;
      $display("FAIL %s hold: got done=%b result=%h expected done=0 result=%h",
               name, done_o, result_o, exp);
    end
  endtask

  task automatic check_no_done(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (done_o !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL %s spurious done: got %0d pulses expected 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset done_o: got %b expected 0", done_o); end
    n_cmp++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset stall_o: got %b expected 0", stall_o); end
    n_cmp++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset result_o: got %h expected 0", result_o); end
    rst_n = 1'b1;
    check_no_done("reset_idle", 3);
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, LAT);
    run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, LAT);
    run_op("remu_max_16", OP_REMU, 32'hFFFFFFFF, 32'h10, 32'hF, LAT);
  endtask

  task automatic test_signed();
    run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
    run_op("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, LAT);
    run_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFFFFF9, 32'd2, LAT);
    run_op("div_m100_m7", OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, LAT);
  endtask

  task automatic test_div_zero();
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, LAT_FAST);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, LAT_FAST);
    run_op("div_m7_0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LAT_FAST);
    run_op("rem_m7_0", OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LAT_FAST);
  endtask

  task automatic test_overflow();
    run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST);
    run_op("rem_min_m1", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, LAT_FAST);
    run_op("divu_min_max", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, LAT);
  endtask

  task automatic test_kill();
    run_op("kill_pre", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT);
    @(negedge clk);
    div_req = 1'b1; ops = OP_DIVU; op1 = 32'd20; op2 = 32'd4;
    repeat (10) @(negedge clk);
    #1;
    kill = 1'b1; div_req = 1'b0;
    @(negedge clk); #1;
    kill = 1'b0;
    n_cmp++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill idle: got stall=%b done=%b expected 0/0", stall_o, done_o);
    end
    n_cmp++;
    if (result_o !== 32'd14) begin
      n_fail++;
      $display("FAIL kill result hold: got %h expected %h", result_o, 32'd14);
    end
    check_no_done("kill", 40);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    div_req = 1'b1; ops = OP_REM; op1 = 32'hFFFFFF9C; op2 = 32'd7;
    repeat (6) @(negedge clk);
    rst_n = 1'b0; div_req = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset outputs: got stall=%b done=%b result=%h expected 0/0/0",
               stall_o, done_o, result_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_no_done("midreset", 40);
    run_op("after_reset_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_rem_m100_7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, LAT);
    run_op("b2b_div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, LAT);
    run_op("b2b_divu_small_big", OP_DIVU, 32'd3, 32'd10, 32'd0, LAT);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
